// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Brief    : 800x600@72Hz SVGA timing constants, coordinate widths, colour
//             type and a window-decode helper shared by the timing generator.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  // Default horizontal timing, in pixels
  localparam int unsigned c_h_active = 800;
  localparam int unsigned c_h_fp     = 56;
  localparam int unsigned c_h_sync   = 120;
  localparam int unsigned c_h_bp     = 64;
  localparam int unsigned c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

  // Default vertical timing, in lines
  localparam int unsigned c_v_active = 600;
  localparam int unsigned c_v_fp     = 37;
  localparam int unsigned c_v_sync   = 6;
  localparam int unsigned c_v_bp     = 23;
  localparam int unsigned c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

  // Widths of the coordinate ports seen by the console
  localparam int unsigned c_h_coord_w = 11;
  localparam int unsigned c_v_coord_w = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // True when pos lies in the half-open window [start, start+len)
  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned start,
                                     input int unsigned len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Brief    : One timing axis (horizontal or vertical): wrapping position
//             counter with active-region and sync-window decode.
//  Revision : 1.0  initial release
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = c_h_total,
  parameter int unsigned ACTIVE     = c_h_active,
  parameter int unsigned SYNC_START = c_h_active + c_h_fp,
  parameter int unsigned SYNC_LEN   = c_h_sync,
  parameter int unsigned W          = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic         wrap,
  output logic [W-1:0] count,
  output logic         active,
  output logic         in_sync
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_last;

  // Next position: advance on enable, fold back to zero after the last slot
  always_comb begin
    at_last = (count_q == W'(TOTAL - 1));
    wrap    = en && at_last;
    count_d = count_q;
    if (en) begin
      count_d = at_last ? '0 : count_q + W'(1);
    end
  end

  // Position register; reset always restarts the axis from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign active  = (32'(count_q) < ACTIVE);
  assign in_sync = in_window(32'(count_q), SYNC_START, SYNC_LEN);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : VGA timing generator. Presents pixel coordinates and display
//             enable to the console, samples its colour reply and drives
//             registered RGB / HSYNC / VSYNC pins plus a frame-start tick.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = 1,
  parameter int unsigned H_ACTIVE = c_h_active,
  parameter int unsigned H_FP     = c_h_fp,
  parameter int unsigned H_SYNC   = c_h_sync,
  parameter int unsigned H_BP     = c_h_bp,
  parameter int unsigned V_ACTIVE = c_v_active,
  parameter int unsigned V_FP     = c_v_fp,
  parameter int unsigned V_SYNC   = c_v_sync,
  parameter int unsigned V_BP     = c_v_bp,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] o_h_coord,
  output logic [9:0]  o_v_coord,
  output logic        o_disp_enbl,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  output logic [3:0]  o_vga_r,
  output logic [3:0]  o_vga_g,
  output logic [3:0]  o_vga_b,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_pix_stb,
  output logic        o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  // Reject timings that cannot be represented on the fixed-width ports
  if (H_TOTAL > 2048) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (PIX_DIV < 1) begin : g_bad_pix_div
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end

  logic          pix_stb;
  logic          h_wrap;
  logic          v_wrap;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          h_active;
  logic          v_active;
  logic          h_in_sync;
  logic          v_in_sync;
  logic          disp_enbl;

  // Pixel strobe: divider only exists when the pixel rate is below clk
  if (PIX_DIV > 1) begin : g_div
    localparam int unsigned DW = $clog2(PIX_DIV);
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    // Divider next state: count up, restart after the strobe cycle
    always_comb begin
      div_d = pix_stb ? '0 : div_q + DW'(1);
    end

    // Divider register
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        div_q <= '0;
      end else begin
        div_q <= div_d;
      end
    end

    assign pix_stb = (div_q == DW'(PIX_DIV - 1));
  end else begin : g_no_div
    assign pix_stb = 1'b1;
  end

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .W          (HW)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pix_stb),
    .wrap    (h_wrap),
    .count   (h_count),
    .active  (h_active),
    .in_sync (h_in_sync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .W          (VW)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (h_wrap),
    .wrap    (v_wrap),
    .count   (v_count),
    .active  (v_active),
    .in_sync (v_in_sync)
  );

  assign disp_enbl = h_active && v_active;

  rgb444_t rgb_in;
  rgb444_t rgb_q;
  rgb444_t rgb_d;
  logic    hsync_q;
  logic    hsync_d;
  logic    vsync_q;
  logic    vsync_d;
  logic    frame_start_q;
  logic    frame_start_d;

  assign rgb_in = {i_red, i_green, i_blue};

  // Pin stage: capture the pixel at the current coords on each strobe so RGB
  // and both syncs leave together one pixel period later
  always_comb begin
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (pix_stb) begin
      rgb_d         = disp_enbl ? rgb_in : '0;
      hsync_d       = h_in_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d       = v_in_sync ? SYNC_POL : ~SYNC_POL;
      frame_start_d = v_wrap;
    end
  end

  // Pin registers; reset blanks the colour and deasserts both syncs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q         <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_h_coord     = 11'(h_count);
  assign o_v_coord     = 10'(v_count);
  assign o_disp_enbl   = disp_enbl;
  assign o_vga_r       = rgb_q.r;
  assign o_vga_g       = rgb_q.g;
  assign o_vga_b       = rgb_q.b;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_pix_stb     = pix_stb;
  assign o_frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Brief    : Directed self-checking bench. Instance A uses the full
//             800x600@72 timing with PIX_DIV=1; instance B uses a shrunken
//             16x10 timing with PIX_DIV=2 and active-low syncs so that whole
//             frames fit in a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic        rst_n_a;
  logic [3:0]  red_a_reg, red_a, green_a, blue_a;
  logic        red_from_h;
  logic [10:0] h_a;
  logic [9:0]  v_a;
  logic        de_a, hs_a, vs_a, stb_a, fs_a;
  logic [3:0]  r_a, g_a, b_a;

  // Instance B signals
  logic        rst_n_b;
  logic [3:0]  red_b, green_b, blue_b;
  logic [10:0] h_b;
  logic [9:0]  v_b;
  logic        de_b, hs_b, vs_b, stb_b, fs_b;
  logic [3:0]  r_b, g_b, b_b;

  // Red channel of A either fixed or echoing the low bits of h
  always_comb begin
    red_a = red_from_h ? h_a[3:0] : red_a_reg;
  end

  vga_timing_gen u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n_a),
    .o_h_coord     (h_a),
    .o_v_coord     (v_a),
    .o_disp_enbl   (de_a),
    .i_red         (red_a),
    .i_green       (green_a),
    .i_blue        (blue_a),
    .o_vga_r       (r_a),
    .o_vga_g       (g_a),
    .o_vga_b       (b_a),
    .o_hsync       (hs_a),
    .o_vsync       (vs_a),
    .o_pix_stb     (stb_a),
    .o_frame_start (fs_a)
  );

  vga_timing_gen #(
    .PIX_DIV  (2),
    .H_ACTIVE (10),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (1),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .SYNC_POL (1'b0)
  ) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n_b),
    .o_h_coord     (h_b),
    .o_v_coord     (v_b),
    .o_disp_enbl   (de_b),
    .i_red         (red_b),
    .i_green       (green_b),
    .i_blue        (blue_b),
    .o_vga_r       (r_b),
    .o_vga_g       (g_b),
    .o_vga_b       (b_b),
    .o_hsync       (hs_b),
    .o_vsync       (vs_b),
    .o_pix_stb     (stb_b),
    .o_frame_start (fs_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hp, vp, hc, vc, p;
    int hs_cnt, hs_rise;
    int fs_cnt, fs_first, fs_last;
    logic hs_prev;

    rst_n_a    = 1'b0;
    rst_n_b    = 1'b0;
    red_a_reg  = 4'h0;
    green_a    = 4'h0;
    blue_a     = 4'h0;
    red_from_h = 1'b0;
    red_b      = 4'hA;
    green_b    = 4'h5;
    blue_b     = 4'hC;
    repeat (3) step();

    // Reset state of both instances
    chk("rst_a_h", h_a, 0);
    chk("rst_a_v", v_a, 0);
    chk("rst_a_de", de_a, 1);
    chk("rst_a_rgb", {r_a, g_a, b_a}, 0);
    chk("rst_a_hs", hs_a, 0);
    chk("rst_a_vs", vs_a, 0);
    chk("rst_a_stb", stb_a, 1);
    chk("rst_a_fs", fs_a, 0);
    chk("rst_b_hs", hs_b, 1);
    chk("rst_b_vs", vs_b, 1);
    chk("rst_b_stb", stb_b, 0);
    chk("rst_b_h", h_b, 0);

    // One full line plus a few pixels with constant white input
    red_a_reg = 4'hF;
    green_a   = 4'hF;
    blue_a    = 4'hF;
    rst_n_a   = 1'b1;
    hs_cnt    = 0;
    hs_rise   = -1;
    hs_prev   = hs_a;
    for (int n = 1; n <= 1045; n++) begin
      step();
      hp = (n - 1) % 1040;
      vp = (n - 1) / 1040;
      hc = n % 1040;
      vc = n / 1040;
      chk("a_h", h_a, hc);
      chk("a_v", v_a, vc);
      chk("a_stb", stb_a, 1);
      chk("a_de", de_a, (hc < 800 && vc < 600) ? 1 : 0);
      chk("a_rgb", {r_a, g_a, b_a}, (hp < 800 && vp < 600) ? 12'hFFF : 12'h000);
      chk("a_hs", hs_a, (hp >= 856 && hp < 976) ? 1 : 0);
      chk("a_vs", vs_a, 0);
      chk("a_fs", fs_a, 0);
      if (hs_a) hs_cnt++;
      if (hs_a && !hs_prev && hs_rise < 0) hs_rise = n;
      hs_prev = hs_a;
    end
    chk("a_hs_width", hs_cnt, 120);
    chk("a_hs_rise", hs_rise, 857);

    // Advance into the hsync pulse of line 1, then reset mid-line
    repeat (1940 - 1045) step();
    chk("a_mid_h", h_a, 900);
    chk("a_mid_v", v_a, 1);
    chk("a_mid_hs", hs_a, 1);
    rst_n_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("a_rst_h", h_a, 0);
      chk("a_rst_v", v_a, 0);
      chk("a_rst_rgb", {r_a, g_a, b_a}, 0);
      chk("a_rst_hs", hs_a, 0);
      chk("a_rst_vs", vs_a, 0);
      chk("a_rst_fs", fs_a, 0);
    end

    // Colour alignment: red follows h[3:0], pins lag one pixel
    red_from_h = 1'b1;
    green_a    = 4'h0;
    blue_a     = 4'h0;
    rst_n_a    = 1'b1;
    for (int n = 1; n <= 1040; n++) begin
      step();
      hp = n - 1;
      chk("a6_h", h_a, n % 1040);
      chk("a6_r", r_a, (hp < 800) ? (hp % 16) : 0);
      chk("a6_gb", {g_a, b_a}, 0);
    end

    // Instance B: divided pixel rate, small frame, active-low syncs
    rst_n_b  = 1'b1;
    fs_cnt   = 0;
    fs_first = -1;
    fs_last  = -1;
    for (int m = 1; m <= 700; m++) begin
      step();
      hc = (m / 2) % 16;
      vc = (m / 32) % 10;
      chk("b_h", h_b, hc);
      chk("b_v", v_b, vc);
      chk("b_stb", stb_b, m % 2);
      chk("b_de", de_b, (hc < 10 && vc < 6) ? 1 : 0);
      if (m < 2) begin
        chk("b_rgb0", {r_b, g_b, b_b}, 0);
        chk("b_hs0", hs_b, 1);
        chk("b_vs0", vs_b, 1);
      end else begin
        p  = m / 2 - 1;
        hp = p % 16;
        vp = (p / 16) % 10;
        chk("b_rgb", {r_b, g_b, b_b}, (hp < 10 && vp < 6) ? 12'hA5C : 12'h000);
        chk("b_hs", hs_b, (hp >= 12 && hp < 15) ? 0 : 1);
        chk("b_vs", vs_b, (vp >= 7 && vp < 9) ? 0 : 1);
      end
      chk("b_fs", fs_b, (m % 320 == 0) ? 1 : 0);
      if (fs_b) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = m;
        fs_last = m;
      end
    end
    chk("b_fs_count", fs_cnt, 2);
    chk("b_fs_period", fs_last - fs_first, 320);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
